// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests, sequences
// exception/ERET redirects as a one-cycle flush, and runs a stall watchdog.
module pipe_ctrl #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned MAX_STALL    = 64,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              excp_req,
  input  logic [ADDR_W-1:0] excp_vector,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              stall_timeout
);

  localparam int unsigned GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_GUARD
  } state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       guard_q, guard_d;
  logic [ADDR_W-1:0]   new_pc_q, new_pc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  // Stall encoding is suppressed during reset and in the flush cycle.
  always_comb begin
    stall = '0;
    if (rst && state_q != ST_FLUSH) begin
      if (stallreq_mem)      stall = 6'b011111;
      else if (stallreq_ex)  stall = 6'b001111;
      else if (stallreq_id)  stall = 6'b000111;
    end
  end

  always_comb begin
    state_d  = state_q;
    guard_d  = guard_q;
    new_pc_d = new_pc_q;
    case (state_q)
      ST_RUN: begin
        if (excp_req) begin
          new_pc_d = excp_vector;
          state_d  = ST_FLUSH;
        end else if (eret_req) begin
          new_pc_d = epc;
          state_d  = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (GUARD_CYCLES == 0) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_GUARD;
          guard_d = GW'(GUARD_CYCLES);
        end
      end
      ST_GUARD: begin
        if (guard_q <= GW'(1)) begin
          state_d = ST_RUN;
          guard_d = '0;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        guard_d = '0;
      end
    endcase
  end

  // Watchdog: the count saturates, and the flag latches on the edge the
  // count reaches MAX_STALL.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (stall != 6'b000000) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(MAX_STALL - 1)) timeout_d = 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      guard_q   <= '0;
      new_pc_q  <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      new_pc_q  <= new_pc_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign flush         = (state_q == ST_FLUSH);
  assign new_pc        = new_pc_q;
  assign stall_cnt     = cnt_q;
  assign stall_timeout = timeout_q;

endmodule
